// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the two-port memory arbiter
//
// Purpose: requester ID type, requester ID constants and the lock FSM
// state enum, shared by mem_arbiter and mem_arb_tagpipe.
// Ports: none (package).
package mem_arb_pkg;

    // Requester identity: 0 = processor core, 1 = host loader.
    typedef logic req_id_t;

    localparam req_id_t REQ_CORE = 1'b0;
    localparam req_id_t REQ_HOST = 1'b1;

    // Bus-lock FSM states (only used when MEM_ARBITER_LOCK_EN is defined).
    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } lock_state_t;

endpackage

// File: rtl/mem_arb_tagpipe.sv
// rtl/mem_arb_tagpipe.sv - fixed-latency read tag pipeline
//
// Purpose: carries a valid bit and requester ID alongside each issued read
// so the read return lines up with the memory's READ_LAT-cycle latency.
// Ports:
//   clock     - clock, posedge
//   rst       - asynchronous active-high reset, empties the pipeline
//   in_valid  - a read was granted this cycle
//   in_id     - requester that issued it
//   out_valid - read data for the tagged read is on mem_dout this cycle
//   out_id    - requester owning that read data
module mem_arb_tagpipe
    import mem_arb_pkg::*;
#(
    parameter int READ_LAT = 2
) (
    input  logic    clock,
    input  logic    rst,
    input  logic    in_valid,
    input  req_id_t in_id,
    output logic    out_valid,
    output req_id_t out_id
);

    logic [READ_LAT-1:0] valid_q;
    logic [READ_LAT-1:0] id_q;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            id_q    <= '0;
        end else begin
            valid_q[0] <= in_valid;
            id_q[0]    <= in_id;
            for (int i = 1; i < READ_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                id_q[i]    <= id_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[READ_LAT-1];
    assign out_id    = id_q[READ_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter for two requesters on one memory port
//
// Purpose: grants at most one of req0 (core) / req1 (host loader) per cycle,
// drives the shared memory port combinationally from the granted request and
// routes read data back READ_LAT cycles later via mem_arb_tagpipe.
// Optional feature: define MEM_ARBITER_LOCK_EN to add req0_lock/req1_lock and
// a bus-lock FSM (ARB/LOCK0/LOCK1) that reserves the port for one requester.
// Ports:
//   clock, rst                          - clock (posedge), async active-high reset
//   reqN_valid/we/addr/wdata            - request channel, held until reqN_ready
//   reqN_lock (MEM_ARBITER_LOCK_EN)     - hold the port for requester N
//   reqN_ready                          - grant; transfer completes on this edge
//   reqN_rvalid/rdata                   - one-cycle read return, rdata 0 otherwise
//   mem_addr/mem_din/mem_we/mem_dout    - shared memory port
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 2
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
`ifdef MEM_ARBITER_LOCK_EN
    input  logic              req0_lock,
    input  logic              req1_lock,
`endif
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout
);

    req_id_t last_grant;
    logic    grant_valid;
    req_id_t grant_id;
    logic    allow0;
    logic    allow1;
    logic    tag_valid;
    req_id_t tag_id;

`ifdef MEM_ARBITER_LOCK_EN
    lock_state_t state_q;
    lock_state_t state_d;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // A lock is taken by the transfer that carries it, and released in the
    // first cycle the owner drops its lock (that cycle still belongs to it).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB: begin
                if (grant_valid && grant_id == REQ_CORE && req0_lock) begin
                    state_d = LOCK0;
                end else if (grant_valid && grant_id == REQ_HOST && req1_lock) begin
                    state_d = LOCK1;
                end
            end
            LOCK0:   if (!req0_lock) state_d = ARB;
            LOCK1:   if (!req1_lock) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        allow0 = (state_q != LOCK1);
        allow1 = (state_q != LOCK0);
    end
`else
    assign allow0 = 1'b1;
    assign allow1 = 1'b1;
`endif

    // Round-robin: on contention the requester not granted most recently wins.
    // Reset is folded in so nothing is granted while rst is held.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = REQ_CORE;
        if (!rst) begin
            if (req0_valid && allow0 && req1_valid && allow1) begin
                grant_valid = 1'b1;
                grant_id    = (last_grant == REQ_HOST) ? REQ_CORE : REQ_HOST;
            end else if (req0_valid && allow0) begin
                grant_valid = 1'b1;
                grant_id    = REQ_CORE;
            end else if (req1_valid && allow1) begin
                grant_valid = 1'b1;
                grant_id    = REQ_HOST;
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            last_grant <= REQ_HOST;
        end else if (grant_valid) begin
            last_grant <= grant_id;
        end
    end

    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = 1'b0;
        if (grant_valid) begin
            if (grant_id == REQ_HOST) begin
                mem_addr = req1_addr;
                mem_din  = req1_wdata;
                mem_we   = req1_we;
            end else begin
                mem_addr = req0_addr;
                mem_din  = req0_wdata;
                mem_we   = req0_we;
            end
        end
    end

    assign req0_ready = grant_valid && (grant_id == REQ_CORE);
    assign req1_ready = grant_valid && (grant_id == REQ_HOST);

    mem_arb_tagpipe #(
        .READ_LAT (READ_LAT)
    ) u_tagpipe (
        .clock     (clock),
        .rst       (rst),
        .in_valid  (grant_valid && !mem_we),
        .in_id     (grant_id),
        .out_valid (tag_valid),
        .out_id    (tag_id)
    );

    assign req0_rvalid = tag_valid && (tag_id == REQ_CORE);
    assign req1_rvalid = tag_valid && (tag_id == REQ_HOST);
    assign req0_rdata  = req0_rvalid ? mem_dout : '0;
    assign req1_rdata  = req1_rvalid ? mem_dout : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        rst;
    logic        req0_valid, req0_we, req1_valid, req1_we;
    logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
`ifdef MEM_ARBITER_LOCK_EN
    logic        req0_lock, req1_lock;
`endif
    logic        req0_ready, req0_rvalid, req1_ready, req1_rvalid;
    logic [31:0] req0_rdata, req1_rdata;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic        mem_we;

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(LAT)) dut (
        .clock      (clock),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req1_valid (req1_valid),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
`ifdef MEM_ARBITER_LOCK_EN
        .req0_lock  (req0_lock),
        .req1_lock  (req1_lock),
`endif
        .req0_ready (req0_ready),
        .req0_rvalid(req0_rvalid),
        .req0_rdata (req0_rdata),
        .req1_ready (req1_ready),
        .req1_rvalid(req1_rvalid),
        .req1_rdata (req1_rdata),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_we     (mem_we),
        .mem_dout   (mem_dout)
    );

    // Synchronous memory with LAT-cycle read latency.
    logic [31:0] mem [256];
    logic [31:0] rd_pipe [LAT];
    always @(posedge clock) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_din;
        rd_pipe[0] <= mem[mem_addr[7:0]];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_dout = rd_pipe[LAT-1];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic        id;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
    } gexp_t;
    typedef struct {
        logic        id;
        logic [31:0] data;
        int          cyc;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int total = 0;
    int bad   = 0;

    // Monitor: pops expectations whenever the DUT presents a grant or a read return.
    always @(negedge clock) begin
        gexp_t g;
        rexp_t r;
        if (rst) begin
            total++;
            if (req0_ready || req1_ready || req0_rvalid || req1_rvalid || mem_we ||
                req0_rdata != 0 || req1_rdata != 0) begin
                bad++;
                $display("FAIL reset_outputs cyc=%0d got rdy=%b%b rv=%b%b we=%b rd0=%h rd1=%h want all 0",
                         cyc, req0_ready, req1_ready, req0_rvalid, req1_rvalid, mem_we, req0_rdata, req1_rdata);
            end
        end else begin
            if (req0_ready || req1_ready) begin
                total++;
                if (gq.size() == 0 || (req0_ready && req1_ready)) begin
                    bad++;
                    $display("FAIL unexpected_grant cyc=%0d got rdy0=%b rdy1=%b want none", cyc, req0_ready, req1_ready);
                end else begin
                    g = gq.pop_front();
                    if (req1_ready != g.id || cyc != g.cyc || mem_we != g.we ||
                        mem_addr != g.addr || mem_din != g.wdata) begin
                        bad++;
                        $display("FAIL grant got id=%0d cyc=%0d we=%b addr=%h din=%h want id=%0d cyc=%0d we=%b addr=%h din=%h",
                                 req1_ready, cyc, mem_we, mem_addr, mem_din, g.id, g.cyc, g.we, g.addr, g.wdata);
                    end
                end
            end else begin
                total++;
                if (gq.size() != 0 && gq[0].cyc == cyc) begin
                    bad++;
                    $display("FAIL missing_grant cyc=%0d got no ready want id=%0d", cyc, gq[0].id);
                    void'(gq.pop_front());
                end else if (mem_we || mem_addr != 0 || mem_din != 0) begin
                    bad++;
                    $display("FAIL idle_port cyc=%0d got we=%b addr=%h din=%h want 0", cyc, mem_we, mem_addr, mem_din);
                end
            end
            if (req0_rvalid || req1_rvalid) begin
                total++;
                if (rq.size() == 0 || (req0_rvalid && req1_rvalid)) begin
                    bad++;
                    $display("FAIL unexpected_rvalid cyc=%0d got rv0=%b rv1=%b want none", cyc, req0_rvalid, req1_rvalid);
                end else begin
                    r = rq.pop_front();
                    if (req1_rvalid != r.id || cyc != r.cyc ||
                        (r.id ? req1_rdata : req0_rdata) != r.data) begin
                        bad++;
                        $display("FAIL read_return got id=%0d cyc=%0d data=%h want id=%0d cyc=%0d data=%h",
                                 req1_rvalid, cyc, r.id ? req1_rdata : req0_rdata, r.id, r.cyc, r.data);
                    end
                end
            end else if (rq.size() != 0 && rq[0].cyc == cyc) begin
                total++;
                bad++;
                $display("FAIL missing_rvalid cyc=%0d got none want id=%0d", cyc, rq[0].id);
                void'(rq.pop_front());
            end
            if ((!req0_rvalid && req0_rdata != 0) || (!req1_rvalid && req1_rdata != 0)) begin
                bad++;
                $display("FAIL rdata_zero cyc=%0d got rd0=%h rd1=%h want 0 when not rvalid", cyc, req0_rdata, req1_rdata);
            end
            total++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic exp_g(input logic id, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input int c);
        gexp_t g;
        g.id = id; g.we = we; g.addr = a; g.wdata = d; g.cyc = c;
        gq.push_back(g);
    endtask

    task automatic exp_r(input logic id, input logic [31:0] d, input int c);
        rexp_t r;
        r.id = id; r.data = d; r.cyc = c;
        rq.push_back(r);
    endtask

    initial begin
        int c;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hA;
        mem[8'h20] = 32'hB;
        mem[8'h03] = 32'h33;
        rst = 1'b1;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h10; req0_wdata = 32'h0;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h20; req1_wdata = 32'h0;
`ifdef MEM_ARBITER_LOCK_EN
        req0_lock = 1'b0; req1_lock = 1'b0;
`endif
        // Reset release with both valid, then continuous contention.
        tick(3);
        rst = 1'b0;
        c = cyc;
        exp_g(1'b0, 1'b0, 32'h10, 32'h0, c);     exp_r(1'b0, 32'hA, c + LAT);
        exp_g(1'b1, 1'b0, 32'h20, 32'h0, c + 1); exp_r(1'b1, 32'hB, c + 1 + LAT);
        exp_g(1'b0, 1'b0, 32'h10, 32'h0, c + 2); exp_r(1'b0, 32'hA, c + 2 + LAT);
        exp_g(1'b1, 1'b0, 32'h20, 32'h0, c + 3); exp_r(1'b1, 32'hB, c + 3 + LAT);
        tick(4);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(4);

        // Host write then read-back of the same address.
        c = cyc;
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h7; req1_wdata = 32'h55;
        exp_g(1'b1, 1'b1, 32'h7, 32'h55, c);
        tick(1);
        req1_we = 1'b0; req1_wdata = 32'h0;
        exp_g(1'b1, 1'b0, 32'h7, 32'h0, c + 1); exp_r(1'b1, 32'h55, c + 1 + LAT);
        tick(1);
        req1_valid = 1'b0;
        tick(4);

        // Reset while a read is in flight: its return must never appear.
        c = cyc;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h3;
        exp_g(1'b0, 1'b0, 32'h3, 32'h0, c);
        tick(1);
        req0_valid = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(6);

        // Idle.
        tick(10);

`ifdef MEM_ARBITER_LOCK_EN
        // Host locks the port for four writes while the core waits.
        c = cyc;
        req1_valid = 1'b1; req1_we = 1'b1; req1_lock = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req1_addr = 32'h30 + k; req1_wdata = k + 1;
            exp_g(1'b1, 1'b1, 32'h30 + k, k + 1, c + k);
            if (k == 1) begin
                req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h10;
            end
            tick(1);
        end
        if (!req0_valid) begin
            req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h10;
        end
        req1_valid = 1'b0; req1_lock = 1'b0; req1_we = 1'b0;
        exp_g(1'b0, 1'b0, 32'h10, 32'h0, c + 5); exp_r(1'b0, 32'hA, c + 5 + LAT);
        tick(2);
        req0_valid = 1'b0;
        tick(4);
`endif

        tick(4);
        total++;
        if (gq.size() != 0 || rq.size() != 0) begin
            bad++;
            $display("FAIL drain got grants_left=%0d reads_left=%0d want 0", gq.size(), rq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter READ_LAT, default 2, memory read latency in cycles (legal range 1..4).
REQ-004 SHALL have port clock  input  1  single clock, all logic on posedge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports reqN_valid  input  1, reqN_we  input  1, reqN_addr  input  ADDR_W, reqN_wdata  input  DATA_W, for N=0 (processor core) and N=1 (host loader): request channel.
REQ-007 SHALL have ports reqN_ready  output  1, reqN_rvalid  output  1, reqN_rdata  output  DATA_W, for N=0 and N=1: grant and read return.
REQ-008 SHALL have ports mem_addr  output  ADDR_W, mem_din  output  DATA_W, mem_we  output  1, mem_dout  input  DATA_W: shared memory port.

Function
REQ-009 SHALL issue at most one request to memory per cycle; the granted requester's addr/wdata/we SHALL drive mem_* combinationally.
REQ-010 SHALL assert reqN_ready in the same cycle as reqN_valid when requester N is granted; the transfer completes on that clock edge.
REQ-011 SHALL hold mem_we=0 in any cycle with no grant, and SHALL drive mem_addr and mem_din to 0 in that cycle.
REQ-012 SHALL arbitrate round-robin: on simultaneous valid, grant the requester not granted most recently; after reset, requester 0 has priority.
REQ-013 SHALL update the last-grant pointer only on a completed transfer.
REQ-014 SHALL grant a lone valid requester immediately, with no idle cycle.
REQ-015 SHALL track each read (granted, we=0) in a READ_LAT-deep tag pipeline and assert reqN_rvalid for exactly one cycle, READ_LAT cycles after the grant edge, with reqN_rdata=mem_dout in that cycle.
REQ-016 SHALL hold reqN_rdata at 0 whenever reqN_rvalid=0.
REQ-017 SHALL return reads in issue order and sustain one read per cycle back-to-back, including alternating requesters.
REQ-018 SHALL produce no rvalid for writes.
REQ-019 SHALL expect a requester to hold valid, we, addr and wdata stable until it sees ready; the arbiter SHALL NOT need to buffer an ungranted request.

Reset
REQ-020 SHALL, on rst, clear all ready/rvalid/rdata outputs to 0, mem_we to 0, the tag pipeline to empty, the last-grant pointer to 1 (so requester 0 wins first), and the lock FSM to ARB.
REQ-021 SHALL discard in-flight reads on rst asserted mid-operation; no rvalid SHALL appear for them after rst deasserts.

Configuration
REQ-022 SHALL, with macro MEM_ARBITER_LOCK_EN defined, add inputs req0_lock and req1_lock (1 bit each) and a 3-state FSM ARB/LOCK0/LOCK1.
- ARB->LOCKN: on a granted transfer from N with reqN_lock=1.
- LOCKN: only N may be granted.
- LOCKN->ARB: on the first cycle reqN_lock=0.
REQ-023 SHALL, without MEM_ARBITER_LOCK_EN, have no lock ports and pure round-robin behaviour; port lists otherwise identical.

Structure
REQ-024 SHALL place the lock FSM state enum and the requester-ID typedef (1 bit) in shared package mem_arb_pkg.
REQ-025 SHALL implement the read-tag pipeline as sub-module mem_arb_tagpipe (parameter READ_LAT; input valid+id; output valid+id).

Verification
REQ-026 Reset: hold rst 3 cycles, both valid=1 at release -> req0_ready=1 in first cycle, req1_ready=1 in next.
REQ-027 Contention: both issue continuous reads to 0x10 (req0) and 0x20 (req1), mem preloaded 0xA/0xB -> grants alternate 0,1,0,1; rvalid alternates with rdata 0xA/0xB, READ_LAT=2 after each grant.
REQ-028 Write then read: req1 writes 0x55 to addr 7, next cycle reads addr 7 -> mem_we=1 one cycle, req1_rvalid 2 cycles later with rdata=0x55, req0 sees no rvalid.
REQ-029 Mid-flight reset: req0 read at addr 3, assert rst the next cycle -> no req0_rvalid ever appears.
REQ-030 Lock (MEM_ARBITER_LOCK_EN): req1 locks, issues 4 writes while req0_valid=1 throughout -> req0_ready=0 for all 4; req0 granted the cycle after req1_lock drops.
REQ-031 Idle: both valid=0 for 10 cycles -> mem_we=0, no ready, no rvalid.
